// File: rtl/ifu_fetch_if.sv
// Instruction-memory fetch bus between the fetch unit and instruction memory.
//   imem_req    : fetch request strobe, one cycle per fetch (fetch -> mem)
//   imem_addr   : word address, valid while imem_req=1      (fetch -> mem)
//   imem_rvalid : response valid                            (mem -> fetch)
//   imem_rdata  : instruction word, valid with imem_rvalid  (mem -> fetch)
interface ifu_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit for the MIPS core. Holds the PC, fetches one word per
// instruction over a request/response handshake, presents it to decode and
// computes the next PC from the control decoder's PC_sel once it retires.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   imem           : fetch bus (master side)
//   instr          : registered instruction presented to decode
//   instr_valid    : instr holds a fetched, not-yet-retired instruction
//   instr_ready    : execute retires the instruction this cycle
//   PC_sel         : 00 pc+4, 01 branch, 10 j/jal, 11 jr
//   branch_taken   : qualifies PC_sel=01
//   rs_data        : jr target
//   pc, pc_plus4   : current instruction address and its link value
//   retire_cnt     : retired instruction count (wraps)
//   addr_err       : sticky, set when a jr target is not word aligned
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic              clk,
  input  logic              rst,
  ifu_fetch_if.master       imem,
  output logic [31:0]       instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic [1:0]        PC_sel,
  input  logic              branch_taken,
  input  logic [31:0]       rs_data,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  output logic [31:0]       retire_cnt,
  output logic              addr_err
);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic        addr_err_q, addr_err_d;
  logic [31:0] npc;
  logic [31:0] br_offset;
  logic        retire;

  assign pc_plus4  = pc_q + 32'd4;
  assign br_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign retire    = (state_q == ST_HOLD) && instr_ready;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    npc = pc_plus4;
    unique case (PC_sel)
      2'b00: npc = pc_plus4;
      2'b01: npc = branch_taken ? (pc_plus4 + br_offset) : pc_plus4;
      2'b10: npc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
      2'b11: npc = {rs_data[31:2], 2'b00};
      default: npc = pc_plus4;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    retire_cnt_d = retire_cnt_q;
    addr_err_d   = addr_err_q;
    unique case (state_q)
      ST_REQ:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (imem.imem_rvalid) begin
          instr_d = imem.imem_rdata;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (retire) begin
          pc_d         = npc;
          retire_cnt_d = retire_cnt_q + 32'd1;
          state_d      = ST_REQ;
          if (PC_sel == 2'b11 && rs_data[1:0] != 2'b00) addr_err_d = 1'b1;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_REQ;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      retire_cnt_q <= '0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      retire_cnt_q <= retire_cnt_d;
      addr_err_q   <= addr_err_d;
    end
  end

  // The request is masked while rst is high so no fetch leaves in the reset cycle.
  assign imem.imem_req  = (state_q == ST_REQ) && !rst;
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = (state_q == ST_HOLD);
  assign pc             = pc_q;
  assign retire_cnt     = retire_cnt_q;
  assign addr_err       = addr_err_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed self-checking bench for ifu_fetch. Inputs change 1 time unit after
// the rising edge; outputs are sampled at that same point.
module tb_ifu_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  PC_sel;
  logic        branch_taken;
  logic [31:0] rs_data;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] retire_cnt;
  logic        addr_err;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  int req_pulses;

  ifu_fetch_if bus ();

  ifu_fetch #(.RESET_PC(32'h0000_3000)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem         (bus),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .PC_sel       (PC_sel),
    .branch_taken (branch_taken),
    .rs_data      (rs_data),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .retire_cnt   (retire_cnt),
    .addr_err     (addr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From a REQ cycle: answer after 'delay' empty WAIT cycles, land in HOLD.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] rdata, input int delay);
    check("req", {31'd0, bus.imem_req}, 32'd1);
    check("req_addr", bus.imem_addr, addr);
    step();
    for (int i = 0; i < delay; i++) step();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = rdata;
    step();
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    check("hold_valid", {31'd0, instr_valid}, 32'd1);
    check("hold_instr", instr, rdata);
  endtask

  // From HOLD: retire with the given control and expect the next REQ address.
  task automatic retire(input logic [1:0] sel, input logic taken,
                        input logic [31:0] rs, input logic [31:0] next_addr);
    PC_sel       = sel;
    branch_taken = taken;
    rs_data      = rs;
    instr_ready  = 1'b1;
    step();
    instr_ready  = 1'b0;
    PC_sel       = 2'b00;
    branch_taken = 1'b0;
    exp_cnt++;
    check("retire_valid_drop", {31'd0, instr_valid}, 32'd0);
    check("retire_cnt", retire_cnt, exp_cnt);
    check("next_pc", pc, next_addr);
  endtask

  initial begin
    rst = 1'b1;
    instr_ready = 1'b0;
    PC_sel = 2'b00;
    branch_taken = 1'b0;
    rs_data = 32'd0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = 32'd0;

    // Reset state
    step();
    step();
    check("rst_req_low", {31'd0, bus.imem_req}, 32'd0);
    check("rst_pc", pc, 32'h0000_3000);
    check("rst_instr", instr, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_cnt", retire_cnt, 32'd0);
    check("rst_err", {31'd0, addr_err}, 32'd0);
    rst = 1'b0;
    #1;

    // Sequential fetches, 3 cycles each
    for (int k = 0; k < 4; k++) begin
      fetch(32'h3000 + 32'(4 * k), 32'h3401_0005, 0);
      retire(2'b00, 1'b0, 32'd0, 32'h3004 + 32'(4 * k));
    end

    // beq taken at 0x3010 -> 0x300C, then back to 0x3010 not taken -> 0x3014
    fetch(32'h3010, 32'h1022_FFFE, 0);
    retire(2'b01, 1'b1, 32'd0, 32'h300C);
    fetch(32'h300C, 32'h3401_0005, 0);
    retire(2'b00, 1'b0, 32'd0, 32'h3010);
    fetch(32'h3010, 32'h1022_FFFE, 0);
    retire(2'b01, 1'b0, 32'd0, 32'h3014);
    fetch(32'h3014, 32'h3401_0005, 0);
    retire(2'b00, 1'b0, 32'd0, 32'h3018);
    fetch(32'h3018, 32'h3401_0005, 0);
    retire(2'b00, 1'b0, 32'd0, 32'h301C);
    fetch(32'h301C, 32'h3401_0005, 0);
    retire(2'b00, 1'b0, 32'd0, 32'h3020);

    // jal at 0x3020
    fetch(32'h3020, 32'h0C00_0C10, 0);
    check("jal_link", pc_plus4, 32'h3024);
    retire(2'b10, 1'b0, 32'd0, 32'h3040);

    // misaligned jr -> 0x3100 and sticky addr_err
    fetch(32'h3040, 32'h03E0_0008, 0);
    check("err_before_jr", {31'd0, addr_err}, 32'd0);
    retire(2'b11, 1'b0, 32'h0000_3102, 32'h3100);
    check("jr_err", {31'd0, addr_err}, 32'd1);
    fetch(32'h3100, 32'h3401_0005, 0);
    retire(2'b00, 1'b0, 32'd0, 32'h3104);
    check("err_sticky", {31'd0, addr_err}, 32'd1);

    // Stall: rvalid ignored in REQ, 5-cycle response delay, ready high in WAIT,
    // ready low 4 cycles in HOLD with rvalid noise
    check("stall_req", {31'd0, bus.imem_req}, 32'd1);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h1111_1111;
    req_pulses = 1;
    step();
    bus.imem_rvalid = 1'b0;
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (bus.imem_req) req_pulses++;
      check("wait_no_valid", {31'd0, instr_valid}, 32'd0);
      step();
    end
    instr_ready = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h2402_0007;
    step();
    check("req_pulses", req_pulses, 32'd1);
    check("stall_instr", instr, 32'h2402_0007);
    for (int i = 0; i < 4; i++) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'h5555_AAAA;
      step();
      check("hold_instr_stable", instr, 32'h2402_0007);
      check("hold_pc_stable", pc, 32'h3104);
      check("hold_cnt_stable", retire_cnt, exp_cnt);
      check("hold_no_req", {31'd0, bus.imem_req}, 32'd0);
    end
    bus.imem_rvalid = 1'b0;
    retire(2'b00, 1'b0, 32'd0, 32'h3108);

    // Address wrap through 0xFFFF_FFFC
    fetch(32'h3108, 32'h0060_0008, 0);
    retire(2'b11, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    check("wrap_plus4", pc_plus4, 32'd0);
    fetch(32'hFFFF_FFFC, 32'h3401_0005, 1);
    retire(2'b00, 1'b0, 32'd0, 32'd0);

    // Reset during WAIT
    step();
    rst = 1'b1;
    step();
    check("rstw_req_low", {31'd0, bus.imem_req}, 32'd0);
    rst = 1'b0;
    #1;
    exp_cnt = 0;
    check("rstw_pc", pc, 32'h3000);
    check("rstw_cnt", retire_cnt, 32'd0);
    check("rstw_valid", {31'd0, instr_valid}, 32'd0);
    check("rstw_err", {31'd0, addr_err}, 32'd0);

    // Reset during HOLD with ready high
    fetch(32'h3000, 32'h3401_0005, 0);
    instr_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    instr_ready = 1'b0;
    #1;
    check("rsth_pc", pc, 32'h3000);
    check("rsth_cnt", retire_cnt, 32'd0);
    check("rsth_valid", {31'd0, instr_valid}, 32'd0);
    check("rsth_instr", instr, 32'd0);
    fetch(32'h3000, 32'h3401_0005, 0);
    retire(2'b00, 1'b0, 32'd0, 32'h3004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit for the MIPS single-cycle-style core; sits directly upstream of the control decoder.
- Holds the PC and fetches one word from instruction memory over a request/response handshake.
- Presents the fetched instruction to decode/execute; the control decoder takes opcode/func from it.
- Computes the next PC from the decoder's PC_sel encoding once the instruction retires.

Parameters:
- RESET_PC, 32'h0000_3000, PC loaded on reset.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request strobe, one cycle per fetch
- imem_addr  out  32  word address to fetch; equals pc while imem_req=1
- imem_rvalid  in  1  instruction memory response valid
- imem_rdata  in  32  instruction word, sampled when imem_rvalid=1 in WAIT
- instr  out  32  registered instruction to decode
- instr_valid  out  1  instr holds a fetched, not-yet-retired instruction
- instr_ready  in  1  execute retires the instruction this cycle
- PC_sel  in  2  from control: 00 pc+4, 01 branch, 10 j/jal, 11 jr
- branch_taken  in  1  ALU compare result (EQL/BNE); qualifies PC_sel=01
- rs_data  in  32  register rs value, jr target
- pc  out  32  address of the current instruction
- pc_plus4  out  32  pc+4, the jal link value
- retire_cnt  out  32  count of retired instructions
- addr_err  out  1  sticky flag: jr target not word aligned

Behaviour:
- Reset (rst=1 at posedge): pc=RESET_PC, state=REQ, instr=0, instr_valid=0, retire_cnt=0, addr_err=0. imem_req=0 in the reset cycle. Reset overrides every other input, including in WAIT or HOLD. Instruction memory shares rst, so no stale response exists after reset.
- FSM states: REQ, WAIT, HOLD.
- REQ: imem_req=1, imem_addr=pc; next state WAIT unconditionally.
- WAIT: imem_req=0. When imem_rvalid=1: instr<=imem_rdata, next state HOLD. Otherwise stay in WAIT with no timeout.
- HOLD: instr_valid=1, instr stable. When instr_ready=1: pc<=npc, retire_cnt<=retire_cnt+1 (wraps at 2^32), instr_valid falls next cycle, next state REQ. Otherwise stay in HOLD.
- imem_rvalid is ignored in REQ and HOLD.
- Minimum throughput is 3 cycles per instruction when rvalid arrives in the first WAIT cycle.
- npc is combinational from instr, pc, PC_sel, branch_taken and rs_data. It is only sampled in HOLD with instr_ready=1.
  - 00: pc+4.
  - 01: if branch_taken, pc+4+(sign_ext(instr[15:0])<<2); else pc+4.
  - 10: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - 11: {rs_data[31:2], 2'b00}. If rs_data[1:0]!=0, addr_err<=1 (sticky until rst).
- All address arithmetic is 32-bit modulo; carry out is dropped, so 0xFFFF_FFFC+4 becomes 0.
- pc_plus4 = pc+4, combinational.
- instr_ready while instr_valid=0 has no effect.

Test Plan:
- Reset, rvalid 1 cycle after req, rdata=0x3401_0005 (ori), PC_sel=00, ready high -> imem_addr 0x3000, 0x3004, 0x3008 on successive REQ cycles 3 cycles apart; retire_cnt increments by 1 per instruction.
- pc=0x3010, instr=0x1022_FFFE (beq, offset -2), PC_sel=01: branch_taken=1 -> next imem_addr=0x300C; branch_taken=0 -> 0x3014.
- pc=0x3020, instr=0x0C00_0C10 (jal), PC_sel=10 -> pc_plus4=0x3024 during HOLD; next imem_addr=0x0000_3040.
- jr with rs_data=0x0000_3102, PC_sel=11 -> next pc=0x3100, addr_err=1 and stays 1 through later fetches until rst.
- rvalid delayed 5 cycles and instr_ready held low 4 cycles in HOLD -> imem_req pulses once; instr stable; pc and retire_cnt unchanged until ready.
- rst asserted during WAIT, then during HOLD with ready=1 -> next cycle pc=0x3000, instr_valid=0, retire_cnt=0; REQ reissued to 0x3000.
